// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request handshake and IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_enable,
  input  logic        if_id_write_enable,
  input  logic        if_id_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_busy
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, hold, hold_nx;
  logic deliver, load;

  assign imem_req   = state == REQ;
  assign imem_addr  = pc;
  assign fetch_busy = state inside {REQ, WAIT, DRAIN};

  always_comb begin
    deliver  = pc_write_enable && if_id_write_enable && !if_id_flush && !branch_taken;
    state_nx = state;
    pc_nx    = pc;
    hold_nx  = hold;
    load     = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ:
        if (branch_taken) begin
          pc_nx = branch_target;
          if (imem_ready) state_nx = DRAIN;
        end else if (imem_ready) state_nx = WAIT;
      WAIT:
        if (branch_taken) begin
          pc_nx    = branch_target;
          state_nx = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid && deliver) begin
          load     = 1'b1;
          pc_nx    = pc + 32'd4;
          state_nx = REQ;
        end else if (imem_rvalid) begin
          hold_nx  = imem_rdata;
          state_nx = HOLD;
        end
      HOLD:
        if (branch_taken) begin
          pc_nx    = branch_target;
          state_nx = REQ;
        end else if (deliver) begin
          load     = 1'b1;
          pc_nx    = pc + 32'd4;
          state_nx = REQ;
        end
      DRAIN: begin
        if (branch_taken) pc_nx = branch_target;
        if (imem_rvalid) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      hold        <= NOP_INSTR;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      hold  <= hold_nx;
      // a bubble keeps the old PC field; only a real delivery rewrites it
      if (branch_taken || if_id_flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (load) begin
        if_id_pc    <= pc;
        if_id_instr <= state == WAIT ? imem_rdata : hold;
        if_id_valid <= 1'b1;
      end else if (if_id_write_enable) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end
endmodule
